// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA priority arbiter: FSM state encoding,
// channel-count limit and a one-hot to index encoder.
package dma_arb_pkg;

    localparam int NUM_CH_MAX = 16;
    localparam int IDX_W_MAX  = $clog2(NUM_CH_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_REQ = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } arb_state_e;

    // OR-encoding is exact for one-hot or all-zero inputs, which is all the arbiter produces.
    function automatic logic [IDX_W_MAX-1:0] onehot_to_idx(input logic [NUM_CH_MAX-1:0] oh);
        logic [IDX_W_MAX-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_CH_MAX; k++) begin
            if (oh[k]) begin
                idx = idx | IDX_W_MAX'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational rotating-priority picker: the set request closest to i_ptr
// (searching upward and wrapping modulo NUM_CH) wins.
module dma_rr_pick
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic              o_found,
    output logic [CH_W-1:0]   o_idx,
    output logic [NUM_CH-1:0] o_onehot
);

    localparam int DW = CH_W + 1;

    logic [DW-1:0]     w_dist [NUM_CH];
    logic [DW-1:0]     w_best;
    logic [NUM_CH-1:0] w_hit;

    // Distance of each channel from the pointer in search order; all distances are distinct.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dist
            assign w_dist[gi] = (DW'(gi) >= DW'(i_ptr)) ?
                                (DW'(gi) - DW'(i_ptr)) :
                                (DW'(gi) + DW'(NUM_CH) - DW'(i_ptr));
        end
    endgenerate

    always_comb begin
        w_best = DW'(NUM_CH);
        w_hit  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_req[k] && (w_dist[k] < w_best)) begin
                w_best   = w_dist[k];
                w_hit    = '0;
                w_hit[k] = 1'b1;
            end
        end
    end

    assign o_found  = |w_hit;
    assign o_onehot = w_hit;
    assign o_idx    = CH_W'(onehot_to_idx(NUM_CH_MAX'(w_hit)));

endmodule

// File: rtl/dma_priority_arbiter.sv
// N-channel DMA request arbiter and HRQ/HLDA hold sequencer with fixed or rotating priority.
// Optional software requests are compiled in with `define DMA_SW_REQUEST_EN.
module dma_priority_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NUM_CH-1:0] i_dreq,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic              i_dma_en,
    input  logic              i_rotate,
    input  logic              i_hlda,
    input  logic              i_xfer_done,
    input  logic              i_sw_req_set,
    input  logic [CH_W-1:0]   i_sw_req_ch,
    output logic              o_hrq,
    output logic [NUM_CH-1:0] o_dack,
    output logic              o_grant_valid,
    output logic [CH_W-1:0]   o_grant_ch,
    output logic [CH_W-1:0]   o_prio_ptr
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic [NUM_CH-1:0] r_req;
    logic [NUM_CH-1:0] r_dack;
    logic [NUM_CH-1:0] w_dack_next;
    logic [CH_W-1:0]   r_grant_ch;
    logic [CH_W-1:0]   w_grant_ch_next;
    logic [CH_W-1:0]   r_prio_ptr;
    logic [CH_W-1:0]   w_ptr_next;
    logic [CH_W-1:0]   w_pick_ptr;
    logic [NUM_CH-1:0] w_eff_req;
    logic              w_pick_found;
    logic [CH_W-1:0]   w_pick_idx;
    logic [NUM_CH-1:0] w_pick_onehot;

`ifdef DMA_SW_REQUEST_EN
    logic [NUM_CH-1:0] r_sw_req;
    logic [NUM_CH-1:0] w_sw_set;
    logic [NUM_CH-1:0] w_sw_clr;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sw
            assign w_sw_set[gi] = i_sw_req_set && (i_sw_req_ch == CH_W'(gi));
            assign w_sw_clr[gi] = (r_state == GRANT) && i_xfer_done && r_dack[gi];
        end
    endgenerate

    // Set is applied after clear so a same-cycle set on the finishing channel survives.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sw_req <= '0;
        end else begin
            r_sw_req <= (r_sw_req & ~w_sw_clr) | w_sw_set;
        end
    end

    assign w_eff_req = (r_req | r_sw_req) & ~i_mask;
`else
    logic w_unused_sw;
    assign w_unused_sw = &{1'b0, i_sw_req_set, i_sw_req_ch};
    assign w_eff_req   = r_req & ~i_mask;
`endif

    assign w_pick_ptr = i_rotate ? r_prio_ptr : '0;

    dma_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .i_req    (w_eff_req),
        .i_ptr    (w_pick_ptr),
        .o_found  (w_pick_found),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_onehot)
    );

    always_comb begin
        w_state_next    = r_state;
        w_dack_next     = r_dack;
        w_grant_ch_next = r_grant_ch;
        w_ptr_next      = r_prio_ptr;
        case (r_state)
            IDLE: begin
                if (i_dma_en && (|w_eff_req)) begin
                    w_state_next = HOLD_REQ;
                end
            end
            HOLD_REQ: begin
                if (!i_dma_en) begin
                    w_state_next = RELEASE;
                end else if (i_hlda) begin
                    if (w_pick_found) begin
                        w_state_next    = GRANT;
                        w_dack_next     = w_pick_onehot;
                        w_grant_ch_next = w_pick_idx;
                    end else begin
                        w_state_next = RELEASE;
                    end
                end
            end
            GRANT: begin
                // Completion takes precedence over a simultaneous HLDA drop.
                if (i_xfer_done) begin
                    w_state_next    = RELEASE;
                    w_dack_next     = '0;
                    w_grant_ch_next = '0;
                    if (i_rotate) begin
                        w_ptr_next = (r_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : r_grant_ch + 1'b1;
                    end
                end else if (!i_hlda) begin
                    w_state_next    = RELEASE;
                    w_dack_next     = '0;
                    w_grant_ch_next = '0;
                end
            end
            RELEASE: begin
                if (!i_hlda) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_dack     <= '0;
            r_grant_ch <= '0;
            r_prio_ptr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_req      <= i_dreq;
            r_dack     <= w_dack_next;
            r_grant_ch <= w_grant_ch_next;
            r_prio_ptr <= i_rotate ? w_ptr_next : '0;
        end
    end

    assign o_hrq         = (r_state == HOLD_REQ) || (r_state == GRANT);
    assign o_dack        = r_dack;
    assign o_grant_valid = |r_dack;
    assign o_grant_ch    = r_grant_ch;
    assign o_prio_ptr    = r_prio_ptr;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter (NUM_CH=4): directed scenarios plus
// randomized services against a priority-order reference model.
module tb_dma_priority_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         i_reset_n;
    logic [N-1:0] i_dreq, i_mask;
    logic         i_dma_en, i_rotate, i_hlda, i_xfer_done, i_sw_req_set;
    logic [1:0]   i_sw_req_ch;
    logic         o_hrq, o_grant_valid;
    logic [N-1:0] o_dack;
    logic [1:0]   o_grant_ch, o_prio_ptr;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;

    dma_priority_arbiter #(.NUM_CH(N)) dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_dreq        (i_dreq),
        .i_mask        (i_mask),
        .i_dma_en      (i_dma_en),
        .i_rotate      (i_rotate),
        .i_hlda        (i_hlda),
        .i_xfer_done   (i_xfer_done),
        .i_sw_req_set  (i_sw_req_set),
        .i_sw_req_ch   (i_sw_req_ch),
        .o_hrq         (o_hrq),
        .o_dack        (o_dack),
        .o_grant_valid (o_grant_valid),
        .o_grant_ch    (o_grant_ch),
        .o_prio_ptr    (o_prio_ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: scan channels in priority order starting at ptr, first active one wins.
    function automatic int model_pick(input logic [N-1:0] eff, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (eff[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_hrq(input string tag);
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            tick();
            seen = o_hrq;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic service(input logic [N-1:0] dreq, input logic [N-1:0] mask,
                           input logic rot, input int hd);
        int           exp_ch;
        logic [N-1:0] exp_oh;
        i_rotate = rot;
        i_mask   = mask;
        i_dreq   = dreq;
        i_dma_en = 1'b1;
        if (!rot) m_ptr = 0;
        exp_ch = model_pick(dreq & ~mask, m_ptr);
        exp_oh = '0;
        exp_oh[exp_ch] = 1'b1;
        wait_hrq("hrq_rise");
        repeat (hd) tick();
        chk("dack_before_hlda", 32'(o_dack), 32'd0);
        i_hlda = 1'b1;
        tick();
        chk("dack_grant", 32'(o_dack), 32'(exp_oh));
        chk("grant_ch", 32'(o_grant_ch), 32'(exp_ch));
        chk("grant_valid", 32'(o_grant_valid), 32'd1);
        chk("hrq_in_grant", 32'(o_hrq), 32'd1);
        i_dreq   = N'($urandom);
        i_mask   = N'($urandom);
        i_dma_en = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        chk("dack_hold", 32'(o_dack), 32'(exp_oh));
        i_xfer_done = 1'b1;
        tick();
        i_xfer_done = 1'b0;
        i_dreq   = '0;
        i_mask   = '0;
        i_dma_en = 1'b1;
        if (rot) m_ptr = (exp_ch + 1) % N;
        $display("[TB] service dreq=%b mask=%b rot=%0d -> ch%0d dack=%b ptr=%0d",
                 dreq, mask, rot, exp_ch, exp_oh, o_prio_ptr);
        chk("dack_done", 32'(o_dack), 32'd0);
        chk("gv_done", 32'(o_grant_valid), 32'd0);
        chk("gch_done", 32'(o_grant_ch), 32'd0);
        chk("hrq_release", 32'(o_hrq), 32'd0);
        chk("prio_ptr", 32'(o_prio_ptr), 32'(m_ptr));
        i_hlda = 1'b0;
        tick();
        tick();
        chk("hrq_idle", 32'(o_hrq), 32'd0);
    endtask

    initial begin
        logic [N-1:0] rd, rm;
        i_reset_n = 1'b0; i_dreq = '0; i_mask = '0; i_dma_en = 1'b0; i_rotate = 1'b0;
        i_hlda = 1'b0; i_xfer_done = 1'b0; i_sw_req_set = 1'b0; i_sw_req_ch = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hrq", 32'(o_hrq), 32'd0);
        chk("rst_dack", 32'(o_dack), 32'd0);
        chk("rst_gv", 32'(o_grant_valid), 32'd0);
        chk("rst_gch", 32'(o_grant_ch), 32'd0);
        chk("rst_ptr", 32'(o_prio_ptr), 32'd0);
        i_reset_n = 1'b1;
        tick();

        // Fixed priority, HLDA two cycles after HRQ
        service(4'b1110, 4'b0000, 1'b0, 2);

        // Rotating over all four channels, then pointer wraps to 0
        for (int s = 0; s < 4; s++) service(4'b1111, 4'b0000, 1'b1, 1);
        chk("rot_wrap_ptr", 32'(o_prio_ptr), 32'd0);

        // Mask after HRQ, before HLDA: no grant, release, stay idle
        i_dreq = 4'b0100;
        wait_hrq("mask_hrq");
        i_mask = 4'b0100;
        tick();
        i_hlda = 1'b1;
        tick();
        chk("mask_no_dack", 32'(o_dack), 32'd0);
        chk("mask_hrq_low", 32'(o_hrq), 32'd0);
        tick();
        chk("mask_release_hold", 32'(o_hrq), 32'd0);
        i_hlda = 1'b0;
        repeat (3) tick();
        chk("mask_idle", 32'(o_hrq), 32'd0);
        $display("[TB] mask/withdraw dack=%b hrq=%0d", o_dack, o_hrq);
        i_dreq = '0;
        i_mask = '0;
        tick();

        // Abort on ch2 with pointer at 2
        service(4'b0010, 4'b0000, 1'b1, 0);
        i_dreq = 4'b0100;
        wait_hrq("abort_hrq");
        i_hlda = 1'b1;
        tick();
        chk("abort_dack", 32'(o_dack), 32'b0100);
        i_dreq = '0;
        i_hlda = 1'b0;
        tick();
        chk("abort_dack_clr", 32'(o_dack), 32'd0);
        chk("abort_ptr", 32'(o_prio_ptr), 32'd2);
        chk("abort_hrq", 32'(o_hrq), 32'd0);
        $display("[TB] abort dack=%b ptr=%0d", o_dack, o_prio_ptr);
        tick();

        // Asynchronous reset in the middle of a grant
        i_dreq = 4'b0100;
        wait_hrq("rstmid_hrq");
        i_hlda = 1'b1;
        tick();
        chk("rstmid_dack", 32'(o_dack), 32'b0100);
        #2 i_reset_n = 1'b0;
        #1;
        chk("rstmid_hrq0", 32'(o_hrq), 32'd0);
        chk("rstmid_dack0", 32'(o_dack), 32'd0);
        chk("rstmid_gv0", 32'(o_grant_valid), 32'd0);
        chk("rstmid_ptr0", 32'(o_prio_ptr), 32'd0);
        $display("[TB] reset mid-grant hrq=%0d dack=%b", o_hrq, o_dack);
        i_dreq = '0;
        i_hlda = 1'b0;
        tick();
        i_reset_n = 1'b1;
        m_ptr = 0;
        repeat (2) tick();
        chk("rstmid_idle", 32'(o_hrq), 32'd0);
        chk("rstmid_ptr_after", 32'(o_prio_ptr), 32'd0);

        // Randomized services against the model
        for (int r = 0; r < 24; r++) begin
            rd = N'($urandom_range(1, 15));
            rm = N'($urandom);
            if ((rd & ~rm) == '0) rm = '0;
            service(rd, rm, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // XFER_DONE outside GRANT leaves the pointer alone
        service(4'b0100, 4'b0000, 1'b1, 0);
        i_xfer_done = 1'b1;
        tick();
        i_xfer_done = 1'b0;
        tick();
        chk("stray_done_ptr", 32'(o_prio_ptr), 32'(m_ptr));
        chk("stray_done_hrq", 32'(o_hrq), 32'd0);

`ifdef DMA_SW_REQUEST_EN
        i_rotate = 1'b0;
        m_ptr = 0;
        i_sw_req_set = 1'b1;
        i_sw_req_ch  = 2'd3;
        tick();
        i_sw_req_set = 1'b0;
        wait_hrq("sw_hrq");
        i_hlda = 1'b1;
        tick();
        chk("sw_dack", 32'(o_dack), 32'b1000);
        i_xfer_done = 1'b1;
        tick();
        i_xfer_done = 1'b0;
        i_hlda = 1'b0;
        repeat (4) tick();
        chk("sw_cleared", 32'(o_hrq), 32'd0);
        $display("[TB] sw request ch3 serviced, hrq=%0d", o_hrq);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
